mux_scan_sequencer: RTL and testbench

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

---
 rtl/mux_scan_sequencer_pkg.sv | 19 +
 rtl/mux_scan_sequencer_rate_divider.sv | 34 +++
 rtl/mux_scan_sequencer.sv | 97 +++++++++
 tb/tb_mux_scan_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// rtl/mux_scan_sequencer_pkg.sv - shared types and constants for the mux scan sequencer
package mux_scan_sequencer_pkg;

    localparam int SEL_WIDTH = 3;
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = 3'd6;
    localparam int CAP_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Divider count width: ceil(log2(div)) but never narrower than one bit
    function automatic int count_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_rate_divider.sv
// rtl/mux_scan_sequencer_rate_divider.sv - free-running divider producing a one-cycle tick
module rate_divider
    import mux_scan_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int CW = count_width(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == CNT_LAST);
    // clear holds the count at zero so the first tick lands TICK_DIV cycles after release
    assign tick      = w_at_last && !clear;

    // Count 0..TICK_DIV-1 and wrap; clear and reset both park the count at zero
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 7-to-1 mux select and captures each selected bit
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 mux_out,
    output logic [SEL_WIDTH-1:0] mux_select,
    output logic [CAP_WIDTH-1:0] captured,
    output logic                 busy,
    output logic                 done
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [SEL_WIDTH-1:0]   w_sel_next;
    logic [CAP_WIDTH-1:0]   r_captured;
    logic [CAP_WIDTH-1:0]   w_cap_next;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_div_clear;
    logic                   w_tick;

    // Divider only runs while scanning, so every scan starts from a zero count
    assign w_div_clear = (r_state != SCAN);

    rate_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_rate_divider (
        .clock  (clock),
        .resetn (resetn),
        .clear  (w_div_clear),
        .tick   (w_tick)
    );

    // Next-state, select and capture logic; start is only looked at in IDLE
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_cap_next   = r_captured;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SCAN;
                    w_sel_next   = '0;
                    w_cap_next   = '0;
                end
            end
            SCAN: begin
                w_busy = 1'b1;
                if (w_tick) begin
                    w_cap_next[r_sel] = mux_out;
                    if (r_sel == SEL_LAST) begin
                        w_state_next = DONE;
                        w_sel_next   = '0;
                    end else begin
                        w_sel_next = r_sel + SEL_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
                w_sel_next   = '0;
            end
            default: begin
                w_state_next = IDLE;
                w_sel_next   = '0;
            end
        endcase
    end

    // State, select and captured word registers with synchronous reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_captured <= '0;
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_captured <= w_cap_next;
        end
    end

    assign mux_select = r_sel;
    assign captured   = r_captured;
    assign busy       = w_busy;
    assign done       = w_done;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - directed self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [6:0] pattern;

    logic [2:0] sel4, sel1;
    logic [6:0] cap4, cap1;
    logic       busy4, busy1, done4, done1;
    logic       mux4, mux1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    // Downstream 7-to-1 mux model driven by the scan pattern
    assign mux4 = (sel4 < 3'd7) ? pattern[sel4] : 1'b0;
    assign mux1 = (sel1 < 3'd7) ? pattern[sel1] : 1'b0;

    mux_scan_sequencer #(.TICK_DIV(4)) dut4 (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .mux_out    (mux4),
        .mux_select (sel4),
        .captured   (cap4),
        .busy       (busy4),
        .done       (done4)
    );

    mux_scan_sequencer #(.TICK_DIV(1)) dut1 (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .mux_out    (mux1),
        .mux_select (sel1),
        .captured   (cap1),
        .busy       (busy1),
        .done       (done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    // One full scan from IDLE; start pulsed at cycle 0, optional pokes and mux toggle
    task automatic scan_check(input bit use1, input bit poke, input bit toggle, input string tag);
        int         td;
        int         last;
        logic [2:0] s;
        logic [6:0] cp;
        logic       b, d;
        td   = use1 ? 1 : 4;
        last = 7 * td + 1;
        next_cycle();
        start = 1'b1;
        for (int c = 1; c <= last + 1; c++) begin
            next_cycle();
            start = poke && (c == 5 || c == 20);
            if (toggle && c == td + 2) pattern[0] = ~pattern[0];
            @(negedge clock);
            s  = use1 ? sel1 : sel4;
            cp = use1 ? cap1 : cap4;
            b  = use1 ? busy1 : busy4;
            d  = use1 ? done1 : done4;
            check_eq($sformatf("%s busy c%0d", tag, c), {31'd0, b}, {31'd0, (c >= 1 && c < last)});
            check_eq($sformatf("%s done c%0d", tag, c), {31'd0, d}, {31'd0, (c == last)});
            check_eq($sformatf("%s sel c%0d", tag, c), {29'd0, s},
                     (c < last) ? 32'((c - 1) / td) : 32'd0);
            if (c == last + 1)
                check_eq($sformatf("%s captured", tag), {25'd0, cp}, 32'h53);
        end
        start   = 1'b0;
        pattern = 7'b1010011;
    endtask

    int done_at[3];
    int nd;

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        pattern = 7'b1010011;
        idle(2);
        @(negedge clock);
        check_eq("rst sel4", {29'd0, sel4}, 32'd0);
        check_eq("rst cap4", {25'd0, cap4}, 32'd0);
        check_eq("rst busy4", {31'd0, busy4}, 32'd0);
        check_eq("rst done4", {31'd0, done4}, 32'd0);
        check_eq("rst sel1", {29'd0, sel1}, 32'd0);
        check_eq("rst cap1", {25'd0, cap1}, 32'd0);
        next_cycle();
        resetn = 1'b1;
        idle(2);

        // TICK_DIV=4 scan with ignored restarts and a late mux_out change on position 0
        scan_check(1'b0, 1'b1, 1'b1, "scan4");
        idle(3);
        // TICK_DIV=1 scan: 7 ticks, done at cycle 8
        scan_check(1'b1, 1'b0, 1'b0, "scan1");
        idle(35);

        // Reset while position 3 is selected
        next_cycle();
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            next_cycle();
            start = 1'b0;
            if (c == 14) resetn = 1'b0;
            @(negedge clock);
            if (c == 14) begin
                check_eq("pre-rst sel4", {29'd0, sel4}, 32'd3);
                check_eq("pre-rst cap4", {25'd0, cap4}, 32'h03);
                check_eq("pre-rst busy4", {31'd0, busy4}, 32'd1);
            end
            if (c == 15) begin
                check_eq("mid-rst sel4", {29'd0, sel4}, 32'd0);
                check_eq("mid-rst cap4", {25'd0, cap4}, 32'd0);
                check_eq("mid-rst busy4", {31'd0, busy4}, 32'd0);
                check_eq("mid-rst done4", {31'd0, done4}, 32'd0);
            end
        end
        next_cycle();
        resetn = 1'b1;
        idle(3);
        @(negedge clock);
        check_eq("idle hold busy4", {31'd0, busy4}, 32'd0);
        check_eq("idle hold cap4", {25'd0, cap4}, 32'd0);
        scan_check(1'b0, 1'b0, 1'b0, "after_rst");
        idle(3);

        // start held high: back-to-back scans with one IDLE cycle between them
        nd = 0;
        next_cycle();
        start = 1'b1;
        for (int c = 1; c <= 91; c++) begin
            next_cycle();
            if (c == 90) start = 1'b0;
            @(negedge clock);
            if (done4) begin
                if (nd < 3) done_at[nd] = c;
                nd++;
            end
            if (c == 30) check_eq("held cap idle", {25'd0, cap4}, 32'h53);
            if (c == 31) check_eq("held cap cleared", {25'd0, cap4}, 32'd0);
        end
        check_eq("held done count", nd, 32'd3);
        if (nd >= 3) begin
            check_eq("held done first", done_at[0], 32'd29);
            check_eq("held done gap1", done_at[1] - done_at[0], 32'd30);
            check_eq("held done gap2", done_at[2] - done_at[1], 32'd30);
        end
        idle(35);
        @(negedge clock);
        check_eq("final busy4", {31'd0, busy4}, 32'd0);
        check_eq("final sel4", {29'd0, sel4}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
